// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared types and constants for the control-register command
// sequencer (reg_seq_ctrl) and its strobe decoder (reg_seq_decode).
//   op_e       - command opcodes as seen on cmd_op
//   state_e    - sequencer FSM states
//   strobe_t   - the eight one-cycle register control strobes
//   op_single  - true for opcodes that always issue exactly one strobe
package reg_seq_pkg;

    localparam int REG_DATA_W    = 4;  // width of the attached control register
    localparam int CNT_W_DEFAULT = 4;  // default repeat-count field width

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SHR  = 3'd5,
        OP_ROR  = 3'd6,
        OP_ROL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic cl;
        logic ld;
        logic inc;
        logic dec;
        logic sr;
        logic ir;
        logic sl;
        logic il;
    } strobe_t;

    // CLR and LOAD ignore the repeat count: one strobe only.
    function automatic logic op_single(input op_e op);
        return (op == OP_CLR) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/reg_seq_decode.sv
// reg_seq_decode: purely combinational strobe generator.
// Maps the sequencer state and latched command onto the register controls.
//   state  in   sequencer state; strobes only fire in ST_ISSUE
//   op     in   latched opcode
//   arg    in   latched argument (LOAD data)
//   fill   in   latched serial fill bit for SHR
//   reg_q  in   register feedback, end bits used as rotate fill
//   rst    in   kill: forces every strobe low this cycle
//   stb    out  cl/ld/inc/dec/sr/ir/sl/il
//   reg_in out  LOAD data, zero whenever ld is low
module reg_seq_decode
    import reg_seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DATA_W = REG_DATA_W
) (
    input  state_e            state,
    input  op_e               op,
    input  logic [CNT_W-1:0]  arg,
    input  logic              fill,
    input  logic [DATA_W-1:0] reg_q,
    input  logic              rst,
    output strobe_t           stb,
    output logic [DATA_W-1:0] reg_in
);

    // Only the end bits of the register feed the rotate fill.
    logic unused_reg_mid;
    assign unused_reg_mid = ^reg_q[DATA_W-2:1];

    always_comb begin
        stb    = '0;
        reg_in = '0;
        if (!rst && state == ST_ISSUE) begin
            unique case (op)
                OP_CLR:  stb.cl = 1'b1;
                OP_LOAD: begin
                    stb.ld = 1'b1;
                    reg_in = DATA_W'(arg);
                end
                OP_INC:  stb.inc = 1'b1;
                OP_DEC:  stb.dec = 1'b1;
                OP_SHR:  begin
                    stb.sr = 1'b1;
                    stb.ir = fill;
                end
                // Rotates read the live register each cycle; it updates on
                // every edge, so chained rotates need no shadow copy.
                OP_ROR:  begin
                    stb.sr = 1'b1;
                    stb.ir = reg_q[0];
                end
                OP_ROL:  begin
                    stb.sl = 1'b1;
                    stb.il = reg_q[DATA_W-1];
                end
                default: ;  // NOP never reaches ISSUE
            endcase
        end
    end

endmodule

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: command sequencer upstream of the 4-bit control register.
// Accepts one command per valid/ready handshake, expands it into a train of
// one-cycle strobes, then pulses done for one cycle.
//   clk, rst         clock; synchronous active-high reset
//   cmd_valid/ready  command handshake
//   cmd_op/arg/fill  opcode, LOAD data or repeat count minus 1, SHR fill bit
//   reg_q            register feedback for rotates
//   cl..il, reg_in   register controls and LOAD data
//   busy, done       strobe train in progress / one-cycle completion pulse
// Optional build macro REG_SEQ_ABORT_EN adds abort (in) and aborted (out):
// abort in ISSUE kills that cycle's strobe and ends the command early.
module reg_seq_ctrl
    import reg_seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_arg,
    input  logic              cmd_fill,
    input  logic [DATA_W-1:0] reg_q,
    output logic              cl,
    output logic              ld,
    output logic              inc,
    output logic              dec,
    output logic              sr,
    output logic              ir,
    output logic              sl,
    output logic              il,
    output logic [DATA_W-1:0] reg_in,
    output logic              busy,
`ifdef REG_SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              done
);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [CNT_W-1:0] arg_q;
    logic             fill_q;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             accept;
    logic             kill;
    strobe_t          stb;

`ifdef REG_SEQ_ABORT_EN
    logic abort_hit;
    logic aborted_q;
    assign abort_hit = (state_q == ST_ISSUE) && abort;
`else
    localparam logic abort_hit = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && cmd_valid;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Command latch: only written on the handshake, so a command held
    // during ISSUE/DONE cannot disturb the one in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_NOP;
            arg_q  <= '0;
            fill_q <= 1'b0;
        end else if (accept) begin
            op_q   <= op_e'(cmd_op);
            arg_q  <= cmd_arg;
            fill_q <= cmd_fill;
        end
    end

`ifdef REG_SEQ_ABORT_EN
    // An abort always leads into DONE next cycle, so this flag is high for
    // exactly that DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) aborted_q <= 1'b0;
        else     aborted_q <= abort_hit;
    end
`endif

    // ---------------- next state / counter ----------------
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e'(cmd_op) == OP_NOP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        rem_d   = op_single(op_e'(cmd_op)) ? '0 : cmd_arg;
                    end
                end
            end
            ST_ISSUE: begin
                // Counter is tested before decrementing, so an all-ones
                // argument yields 2^CNT_W strobes and never underflows.
                if (abort_hit || rem_q == '0) state_d = ST_DONE;
                else                          rem_d   = rem_q - 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ISSUE);
    assign done      = (state_q == ST_DONE) && !rst;
`ifdef REG_SEQ_ABORT_EN
    assign aborted   = done && aborted_q;
`endif

    // Reset (and abort) gate the strobes combinationally so the register
    // sees no operation in that very cycle.
    assign kill = rst || abort_hit;

    reg_seq_decode #(
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) u_decode (
        .state  (state_q),
        .op     (op_q),
        .arg    (arg_q),
        .fill   (fill_q),
        .reg_q  (reg_q),
        .rst    (kill),
        .stb    (stb),
        .reg_in (reg_in)
    );

    assign cl  = stb.cl;
    assign ld  = stb.ld;
    assign inc = stb.inc;
    assign dec = stb.dec;
    assign sr  = stb.sr;
    assign ir  = stb.ir;
    assign sl  = stb.sl;
    assign il  = stb.il;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed bench for reg_seq_ctrl. A behavioural 4-bit register model is
// attached to the strobes and fed back on reg_q. Inputs change and outputs
// are checked on the falling edge; stb = {cl,ld,inc,dec,sr,ir,sl,il}.
module tb_reg_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       cmd_fill;
    logic [3:0] reg_q;
    logic       cl, ld, inc, dec, sr, ir, sl, il;
    logic [3:0] reg_in;
    logic       busy, done;
`ifdef REG_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    logic [7:0] stb;
    assign stb = {cl, ld, inc, dec, sr, ir, sl, il};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_seq_ctrl #(.CNT_W(4), .DATA_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_fill  (cmd_fill),
        .reg_q     (reg_q),
        .cl        (cl),
        .ld        (ld),
        .inc       (inc),
        .dec       (dec),
        .sr        (sr),
        .ir        (ir),
        .sl        (sl),
        .il        (il),
        .reg_in    (reg_in),
        .busy      (busy),
`ifdef REG_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .done      (done)
    );

    // Control register model with its own synchronous reset.
    always @(posedge clk) begin
        if (rst)      reg_q <= 4'h0;
        else if (cl)  reg_q <= 4'h0;
        else if (ld)  reg_q <= reg_in;
        else if (inc) reg_q <= reg_q + 4'h1;
        else if (dec) reg_q <= reg_q - 4'h1;
        else if (sr)  reg_q <= {ir, reg_q[3:1]};
        else if (sl)  reg_q <= {reg_q[2:0], il};
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a command at a falling edge; returns at the falling edge of
    // the first ISSUE (or DONE for NOP) cycle. hold keeps cmd_valid high.
    task automatic send(input logic [2:0] op, input logic [3:0] arg,
                        input logic fill, input logic hold);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        chk("ready_at_hs", cmd_ready, 1);
        step();
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        send(3'd2, v, 1'b0, 1'b0);
        chk("ld_stb", stb, 8'h40);
        chk("ld_data", reg_in, v);
        step();
        chk("ld_done", done, 1);
        chk("ld_q", reg_q, v);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 4'h0;
        cmd_fill  = 1'b0;
`ifdef REG_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        step();
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stb", stb, 8'h00);
        chk("rst_regin", reg_in, 4'h0);
        rst = 1'b0;

        // LOAD 0xA: ld + data at T+1, done at T+2
        load(4'hA);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_done", done, 0);

        // INC arg=2 from 0xE, wraps F -> 0
        load(4'hE);
        send(3'd3, 4'd2, 1'b0, 1'b0);
        chk("inc1_stb", stb, 8'h20);
        chk("inc1_busy", busy, 1);
        chk("inc1_ready", cmd_ready, 0);
        step();
        chk("inc2_stb", stb, 8'h20);
        chk("inc2_q", reg_q, 4'hF);
        step();
        chk("inc3_stb", stb, 8'h20);
        chk("inc3_q", reg_q, 4'h0);
        step();
        chk("inc_done", done, 1);
        chk("inc_busy", busy, 0);
        chk("inc_end_stb", stb, 8'h00);
        chk("inc_q", reg_q, 4'h1);
        step();

        // ROR arg=3 from 0x9: 9 -> C -> 6 -> 3 -> 9, ir follows reg_q[0]
        load(4'h9);
        send(3'd6, 4'd3, 1'b0, 1'b0);
        chk("ror1_stb", stb, 8'h0C);
        step();
        chk("ror2_q", reg_q, 4'hC);
        chk("ror2_stb", stb, 8'h08);
        step();
        chk("ror3_q", reg_q, 4'h6);
        chk("ror3_stb", stb, 8'h08);
        step();
        chk("ror4_q", reg_q, 4'h3);
        chk("ror4_stb", stb, 8'h0C);
        step();
        chk("ror_done", done, 1);
        chk("ror_q", reg_q, 4'h9);
        step();

        // ROL arg=0 from 0x8 -> 0x1
        load(4'h8);
        send(3'd7, 4'd0, 1'b0, 1'b0);
        chk("rol_stb", stb, 8'h03);
        step();
        chk("rol_done", done, 1);
        chk("rol_q", reg_q, 4'h1);
        step();

        // CLR, then SHR arg=1 fill=1 with a held follow-up INC arg=0
        send(3'd1, 4'hF, 1'b0, 1'b0);
        chk("clr_stb", stb, 8'h80);
        step();
        chk("clr_done", done, 1);
        chk("clr_q", reg_q, 4'h0);
        step();
        send(3'd5, 4'd1, 1'b1, 1'b1);
        cmd_op   = 3'd3;   // next command waits on the bus
        cmd_arg  = 4'd0;
        cmd_fill = 1'b0;
        chk("shr1_stb", stb, 8'h0C);
        chk("shr1_ready", cmd_ready, 0);
        step();
        chk("shr2_stb", stb, 8'h0C);
        chk("shr2_q", reg_q, 4'h8);
        step();
        chk("shr_done", done, 1);
        chk("shr_done_ready", cmd_ready, 0);
        chk("shr_done_stb", stb, 8'h00);
        chk("shr_q", reg_q, 4'hC);
        step();
        chk("held_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("held_inc_stb", stb, 8'h20);
        step();
        chk("held_done", done, 1);
        chk("held_q", reg_q, 4'hD);
        step();

        // NOP: straight to DONE, no strobes
        send(3'd0, 4'h5, 1'b0, 1'b0);
        chk("nop_done", done, 1);
        chk("nop_busy", busy, 0);
        chk("nop_stb", stb, 8'h00);
        chk("nop_q", reg_q, 4'hD);
        step();

        // DEC arg=5, reset on its second ISSUE cycle
        send(3'd4, 4'd5, 1'b0, 1'b0);
        chk("dec1_stb", stb, 8'h10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("decrst_stb", stb, 8'h00);
        chk("decrst_done", done, 0);
        chk("decrst_q", reg_q, 4'hC);
        step();
        chk("postrst_ready", cmd_ready, 1);
        chk("postrst_busy", busy, 0);
        chk("postrst_done", done, 0);
        chk("postrst_q", reg_q, 4'h0);
        rst = 1'b0;
        step();
        chk("postrst2_done", done, 0);
        chk("postrst2_stb", stb, 8'h00);

`ifdef REG_SEQ_ABORT_EN
        // INC arg=7 from 0, abort on the third ISSUE cycle
        send(3'd3, 4'd7, 1'b0, 1'b0);
        chk("ab1_stb", stb, 8'h20);
        step();
        chk("ab2_stb", stb, 8'h20);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("ab3_stb", stb, 8'h00);
        chk("ab3_q", reg_q, 4'h2);
        abort = 1'b0;
        step();
        chk("ab_done", done, 1);
        chk("ab_aborted", aborted, 1);
        chk("ab_q", reg_q, 4'h2);
        step();
        chk("ab_ready", cmd_ready, 1);
        chk("ab_clear", aborted, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
